// File: rtl/jam_rotator.sv
// Jam-mode light sequencer: enables the jam counter and rotates green
// round-robin among jammed roads, inserting a yellow interval per handover.
module jam_rotator #(
    parameter int NUM_ROADS     = 4,
    parameter int YELLOW_CYCLES = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_ROADS-1:0]         i_jam_flags,
    input  logic                         i_jam_start,
    input  logic                         i_jam_rotation,
    output logic                         o_jam_counter_en,
    output logic [NUM_ROADS-1:0]         o_green,
    output logic [NUM_ROADS-1:0]         o_yellow,
    output logic [$clog2(NUM_ROADS)-1:0] o_jam_road,
    output logic                         o_jam_active
);

    localparam int RW = $clog2(NUM_ROADS);
    localparam int CW = $clog2(YELLOW_CYCLES + 1);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_START = 2'd1;
    localparam logic [1:0] S_GREEN      = 2'd2;
    localparam logic [1:0] S_YELLOW     = 2'd3;

    localparam logic [RW-1:0]        PTR_RST  = RW'(NUM_ROADS - 1);
    localparam logic [CW-1:0]        CNT_LOAD = CW'(YELLOW_CYCLES);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [NUM_ROADS-1:0] LIGHTS_OFF = {NUM_ROADS{1'b0}};

    // Round-robin search from ptr+1, wrapping; the current road comes last.
    // Iterating from the farthest offset down lets the nearest hit win.
    function automatic logic [RW:0] f_select(input logic [NUM_ROADS-1:0] flags,
                                             input logic [RW-1:0]        ptr);
        logic [RW:0]   res;
        logic [RW-1:0] idx;
        int            p;
        res = {(RW+1){1'b0}};
        for (int k = NUM_ROADS; k >= 1; k--) begin
            p = int'(ptr) + k;
            if (p >= NUM_ROADS) begin
                p = p - NUM_ROADS;
            end
            idx = RW'(p);
            if (flags[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_ROADS-1:0] f_onehot(input logic [RW-1:0] idx);
        logic [NUM_ROADS-1:0] v;
        v = LIGHTS_OFF;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [1:0]           r_state;
    logic [RW-1:0]        r_ptr;
    logic [CW-1:0]        r_cnt;
    logic [NUM_ROADS-1:0] r_green;
    logic [NUM_ROADS-1:0] r_yellow;
    logic [RW-1:0]        r_road;
    logic                 r_en;
    logic                 r_active;

    logic [1:0]           w_state_n;
    logic [RW-1:0]        w_ptr_n;
    logic [CW-1:0]        w_cnt_n;
    logic [NUM_ROADS-1:0] w_green_n;
    logic [NUM_ROADS-1:0] w_yellow_n;
    logic [RW-1:0]        w_road_n;
    logic                 w_en_n;
    logic                 w_active_n;

    logic [RW:0]          w_sel;
    logic                 w_found;
    logic [RW-1:0]        w_idx;
    logic                 w_any_jam;

    assign w_sel     = f_select(i_jam_flags, r_ptr);
    assign w_found   = w_sel[RW];
    assign w_idx     = w_sel[RW-1:0];
    assign w_any_jam = |i_jam_flags;

    // Next-state and next-output decode; every output is computed here and registered below.
    always_comb begin
        w_state_n  = r_state;
        w_ptr_n    = r_ptr;
        w_cnt_n    = r_cnt;
        w_green_n  = r_green;
        w_yellow_n = r_yellow;
        w_road_n   = r_road;
        w_en_n     = r_en;
        w_active_n = r_active;
        case (r_state)
            S_IDLE: begin
                if (w_any_jam) begin
                    w_state_n = S_WAIT_START;
                    w_en_n    = 1'b1;
                end else begin
                    w_state_n  = S_IDLE;
                    w_en_n     = 1'b0;
                    w_green_n  = LIGHTS_OFF;
                    w_yellow_n = LIGHTS_OFF;
                    w_active_n = 1'b0;
                end
            end
            S_WAIT_START: begin
                if (i_jam_start && w_found) begin
                    w_state_n  = S_GREEN;
                    w_green_n  = f_onehot(w_idx);
                    w_yellow_n = LIGHTS_OFF;
                    w_road_n   = w_idx;
                    w_ptr_n    = w_idx;
                    w_active_n = 1'b1;
                    w_en_n     = 1'b1;
                end else if (!w_any_jam) begin
                    w_state_n  = S_IDLE;
                    w_en_n     = 1'b0;
                    w_road_n   = {RW{1'b0}};
                    w_active_n = 1'b0;
                end else begin
                    w_state_n = S_WAIT_START;
                end
            end
            S_GREEN: begin
                // A lone jammed road keeps its green across the rotation.
                if (i_jam_rotation && !(w_found && (w_idx == r_ptr))) begin
                    w_state_n  = S_YELLOW;
                    w_green_n  = LIGHTS_OFF;
                    w_yellow_n = f_onehot(r_road);
                    w_cnt_n    = CNT_LOAD;
                end else begin
                    w_state_n = S_GREEN;
                end
            end
            S_YELLOW: begin
                if (r_cnt == CNT_ONE) begin
                    w_yellow_n = LIGHTS_OFF;
                    if (w_found) begin
                        w_state_n  = S_GREEN;
                        w_green_n  = f_onehot(w_idx);
                        w_road_n   = w_idx;
                        w_ptr_n    = w_idx;
                        w_active_n = 1'b1;
                        w_en_n     = 1'b1;
                    end else begin
                        w_state_n  = S_IDLE;
                        w_green_n  = LIGHTS_OFF;
                        w_road_n   = {RW{1'b0}};
                        w_active_n = 1'b0;
                        w_en_n     = 1'b0;
                    end
                end else begin
                    w_cnt_n = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_n  = S_IDLE;
                w_green_n  = LIGHTS_OFF;
                w_yellow_n = LIGHTS_OFF;
                w_road_n   = {RW{1'b0}};
                w_active_n = 1'b0;
                w_en_n     = 1'b0;
            end
        endcase
    end

    // State, pointer, yellow counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= PTR_RST;
            r_cnt    <= {CW{1'b0}};
            r_green  <= LIGHTS_OFF;
            r_yellow <= LIGHTS_OFF;
            r_road   <= {RW{1'b0}};
            r_en     <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_ptr    <= w_ptr_n;
            r_cnt    <= w_cnt_n;
            r_green  <= w_green_n;
            r_yellow <= w_yellow_n;
            r_road   <= w_road_n;
            r_en     <= w_en_n;
            r_active <= w_active_n;
        end
    end

    assign o_jam_counter_en = r_en;
    assign o_green          = r_green;
    assign o_yellow         = r_yellow;
    assign o_jam_road       = r_road;
    assign o_jam_active     = r_active;

endmodule

// File: doc/jam_rotator.md
# jam_rotator

Jam-mode light sequencer for the traffic controller. It watches the per-road jam flags and drives `jam_counter_en` to the jam counter. It consumes the counter's `jam_start` and `jam_rotation` pulses to hand the green light round-robin among jammed roads. Each handover goes through a yellow interval. It sits directly downstream of the jam counter and is the only driver of its enable.

## Interface
- `NUM_ROADS`, default 4: number of roads/approaches. Must be ≥ 2.
- `YELLOW_CYCLES`, default 3: length of the yellow interval in cycles. Legal range 1..14, so it always ends before the next 15-cycle rotation.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `jam_flags`, input, NUM_ROADS: bit i high means road i is jammed. Level input, synchronous to `clk`.
- `jam_start`, input, 1: one-cycle pulse from the jam counter marking the start of jam mode.
- `jam_rotation`, input, 1: one-cycle pulse from the jam counter marking the end of a slot (15 cycles).
- `jam_counter_en`, output, 1: enables the jam counter. High in every state except IDLE.
- `green`, output, NUM_ROADS: one-hot green for the served road, or all zeros.
- `yellow`, output, NUM_ROADS: one-hot yellow for the road being released, or all zeros.
- `jam_road`, output, $clog2(NUM_ROADS): index of the road last granted green.
- `jam_active`, output, 1: high in the GREEN and YELLOW states.

## Operation
- FSM states: IDLE, WAIT_START, GREEN, YELLOW.
- All outputs are registered.
- `green` and `yellow` are never nonzero in the same cycle.
- **IDLE**
  - All outputs are low.
  - When `|jam_flags` goes high: go to WAIT_START and set `jam_counter_en`=1.
- **WAIT_START**
  - If `jam_start`=1: select a road (see selection rule), drive its `green` bit, update `jam_road` and the pointer, go to GREEN.
  - Else if `jam_flags`==0: go to IDLE and drop `jam_counter_en`.
- **GREEN**
  - Pulses other than `jam_rotation` are ignored.
  - On `jam_rotation`, compute the next road:
    - Next road equals the current road (it is the only one jammed): stay in GREEN, no yellow, lights unchanged.
    - Next road differs, or no road is jammed: clear `green`, set `yellow[jam_road]`, load the yellow counter, go to YELLOW.
- **YELLOW**
  - Hold `yellow` for exactly YELLOW_CYCLES cycles, then:
    - If `|jam_flags`: select the next road, drive its green, go to GREEN.
    - Else: go to IDLE, all outputs low, `jam_counter_en`=0.
  - `jam_start` and `jam_rotation` are ignored.
- **Selection rule (round-robin)**
  - Search the lowest-numbered jammed road starting at `(ptr+1) mod NUM_ROADS` and wrapping. The current road is checked last.
  - `ptr` is the index of the last road granted green. It resets to NUM_ROADS-1, so the first search starts at road 0.
  - `jam_flags` are sampled in the cycle of the deciding event.
- The yellow counter is $clog2(YELLOW_CYCLES+1) bits wide and counts down to 1. It does not wrap.

## Timing
- Reset values:
  - State IDLE, `ptr`=NUM_ROADS-1.
  - `jam_counter_en`=0, `green`=0, `yellow`=0, `jam_road`=0, `jam_active`=0.
- Reset asserted mid-operation clears everything immediately (asynchronously). No yellow is produced.
- `jam_flags` high at edge k → `jam_counter_en` high after edge k.
- `jam_start` sampled at edge k → `green` valid after edge k (latency 1).
- `jam_rotation` at edge k → `yellow` from edge k through edge k+YELLOW_CYCLES. Next `green` or IDLE takes effect at edge k+YELLOW_CYCLES.
- The yellow interval consumes the first YELLOW_CYCLES cycles of the next 15-cycle slot. The green then lasts 15−YELLOW_CYCLES cycles.
- `jam_rotation` arriving in the same cycle as the final yellow cycle is ignored.

## Test plan
1. Reset with `jam_flags`=0 → all outputs 0. Then assert `jam_flags`=4'b0100 → `jam_counter_en`=1 one cycle later. Pulse `jam_start` → `green`=4'b0100, `jam_road`=2.
2. `jam_flags`=4'b1011, green on road 0, pulse `jam_rotation` → `yellow`=4'b0001 for 3 cycles, then `green`=4'b0010. Next rotation gives road 3, then road 0 (wrap).
3. Only road 1 jammed, in GREEN on road 1, pulse `jam_rotation` → no yellow, `green` stays 4'b0010.
4. Clear all flags while in GREEN on road 2, then pulse `jam_rotation` → `yellow`=4'b0100 for 3 cycles, then IDLE with `jam_counter_en`=0 and `jam_active`=0.
5. Assert flags, then clear them before `jam_start` → WAIT_START returns to IDLE and `jam_counter_en` drops. A later `jam_start` pulse in IDLE is ignored.
6. Assert `rst_n`=0 during YELLOW → all outputs 0 immediately. After release, the first grant goes to the lowest jammed road, since `ptr` is reset.
